// File: rtl/imm_field_encoder_pkg.sv
// Shared definitions for the immediate field encoder.
//
// Holds the ImmSrc format encodings, the legal immediate ranges per format, the
// saturation limit of the error counter and a small range-check helper.

package imm_field_encoder_pkg;

    // ImmSrc encodings; 2'b11 is reserved and always rejected.
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    // I and S formats carry a 12-bit signed immediate.
    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;

    // B format carries a 13-bit signed, even immediate (bit 0 is implicit zero).
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;

    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // True when the 32-bit two's-complement value lies within [lo, hi].
    function automatic logic imm_in_range(input logic signed [31:0] value,
                                          input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational immediate packer.
//
// Scatters a signed immediate into the RISC-V I/S/B instruction bit-fields and
// merges it into a base instruction word; every bit outside the format's
// immediate fields is passed through from base. Flags immediates that cannot be
// represented in the selected format, and the reserved format code.
//
// Ports:
//   imm_src  format select (IMM_I / IMM_S / IMM_B, 2'b11 reserved)
//   imm      signed immediate to encode
//   base     instruction word supplying all non-immediate bits
//   instr    merged instruction word
//   illegal  immediate out of range, misaligned (B) or reserved format

module imm_field_pack
    import imm_field_encoder_pkg::*;
(
    input  logic [1:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] instr,
    output logic        illegal
);

    always_comb begin
        instr   = base;
        illegal = 1'b0;
        case (imm_src)
            IMM_I: begin
                instr[31:20] = imm[11:0];
                illegal      = !imm_in_range(imm, IMM_IS_MIN, IMM_IS_MAX);
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                illegal      = !imm_in_range(imm, IMM_IS_MIN, IMM_IS_MAX);
            end
            IMM_B: begin
                // imm[0] has no slot in the B format, so an odd value is unencodable.
                instr[31]    = imm[12];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                instr[7]     = imm[11];
                illegal      = !imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_field_encoder.sv
// Immediate field encoder with instruction-memory write stream.
//
// Accepts (ImmSrc, Imm, Base, Last) items, encodes the immediate into the base
// instruction and presents the word with a sequential byte write address. A
// single output register gives one-cycle latency and full throughput with
// pass-through ready. Unencodable items are consumed silently and recorded in
// a sticky error flag and a saturating error counter.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   In_Valid, In_Ready   input handshake
//   ImmSrc, Imm, Base    format, immediate, base instruction word
//   Last                 final item of a program
//   Out_Valid, Out_Ready output handshake
//   Instr_Out, Addr_Out  encoded word and its write address
//   Err, Err_Clr         sticky error flag and its clear
//   Err_Count            saturating count of rejected items
//   Done                 one-cycle pulse when a program completes

module imm_field_encoder
    import imm_field_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned ADDR_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [1:0]        ImmSrc,
    input  logic [31:0]       Imm,
    input  logic [31:0]       Base,
    input  logic              Last,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [31:0]       Instr_Out,
    output logic [ADDR_W-1:0] Addr_Out,
    output logic              Err,
    input  logic              Err_Clr,
    output logic [7:0]        Err_Count,
    output logic              Done
);

    localparam logic [ADDR_W-1:0] StartAddr = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] AddrStep  = ADDR_W'(ADDR_STEP);

    logic [31:0] pack_instr;
    logic        pack_illegal;

    imm_field_pack u_pack (
        .imm_src (ImmSrc),
        .imm     (Imm),
        .base    (Base),
        .instr   (pack_instr),
        .illegal (pack_illegal)
    );

    logic              out_valid_q, out_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic              last_q, last_d;      // Last flag of the held word
    logic [ADDR_W-1:0] addr_q, addr_d;      // address of the next word to be written
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              done_q, done_d;

    logic              in_hs;
    logic              out_hs;
    logic              acc_word;
    logic              acc_err;
    logic [ADDR_W-1:0] addr_next;

    assign In_Ready = !out_valid_q || Out_Ready;
    assign in_hs    = In_Valid && In_Ready;
    assign out_hs   = out_valid_q && Out_Ready;
    assign acc_word = in_hs && !pack_illegal;
    assign acc_err  = in_hs && pack_illegal;

    // Address bookkeeping. The address only moves when a word leaves, so a word
    // accepted in the same cycle as a handshake already sees the advanced (or
    // reloaded, if the departing word ended a program) address.
    always_comb begin
        addr_next = addr_q;
        if (out_hs) begin
            addr_next = last_q ? StartAddr : addr_q + AddrStep;
        end
        addr_d = addr_next;
        if (acc_err && Last) begin
            addr_d = StartAddr;
        end
    end

    // Output register: load on a legal acceptance, otherwise hold the word and
    // drop valid once it has been taken.
    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        addr_out_d  = addr_out_q;
        last_d      = last_q;
        if (acc_word) begin
            out_valid_d = 1'b1;
            instr_d     = pack_instr;
            addr_out_d  = addr_next;
            last_d      = Last;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    // Error tracking; a rejection in the same cycle as a clear counts as the
    // first error after the clear.
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (Err_Clr) begin
            err_d     = 1'b0;
            err_cnt_d = 8'd0;
        end
        if (acc_err) begin
            err_d = 1'b1;
            if (Err_Clr) begin
                err_cnt_d = 8'd1;
            end else if (err_cnt_q != ERR_COUNT_MAX) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    assign done_d = (out_hs && last_q) || (acc_err && Last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            instr_q     <= 32'd0;
            addr_out_q  <= '0;
            last_q      <= 1'b0;
            addr_q      <= StartAddr;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            addr_out_q  <= addr_out_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            done_q      <= done_d;
        end
    end

    assign Out_Valid = out_valid_q;
    assign Instr_Out = instr_q;
    assign Addr_Out  = addr_out_q;
    assign Err       = err_q;
    assign Err_Count = err_cnt_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Scoreboard bench for imm_field_encoder: the stimulus process pushes expected
// words into a queue, the monitor pops and compares on every output handshake.

module tb_imm_field_encoder;
    import imm_field_encoder_pkg::*;

    localparam int unsigned ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              In_Valid;
    logic              In_Ready;
    logic [1:0]        ImmSrc;
    logic [31:0]       Imm;
    logic [31:0]       Base;
    logic              Last;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [31:0]       Instr_Out;
    logic [ADDR_W-1:0] Addr_Out;
    logic              Err;
    logic              Err_Clr;
    logic [7:0]        Err_Count;
    logic              Done;

    imm_field_encoder #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (0),
        .ADDR_STEP  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .ImmSrc    (ImmSrc),
        .Imm       (Imm),
        .Base      (Base),
        .Last      (Last),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Instr_Out (Instr_Out),
        .Addr_Out  (Addr_Out),
        .Err       (Err),
        .Err_Clr   (Err_Clr),
        .Err_Count (Err_Count),
        .Done      (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              chk_instr;  // 1: compare exact word, 0: round-trip decode
        logic [31:0]       instr;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        src;
        logic [31:0]       imm;
    } exp_t;

    exp_t              sb[$];
    exp_t              mon_e;
    int                checks = 0;
    int                failures = 0;
    int                done_pulses = 0;
    logic [ADDR_W-1:0] exp_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Independent immediate extraction, as the datapath decoder would do it.
    function automatic logic [31:0] decode(input logic [1:0] src, input logic [31:0] i);
        case (src)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            default: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        endcase
    endfunction

    // Monitor: a handshake seen at the falling edge completes on the next rise.
    always @(negedge clk) begin
        if (rst_n && Out_Valid && Out_Ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got instr 0x%0h addr 0x%0h, want no word",
                         Instr_Out, Addr_Out);
            end else begin
                mon_e = sb.pop_front();
                check("addr_out", 64'(Addr_Out), 64'(mon_e.addr));
                if (mon_e.chk_instr) begin
                    check("instr_out", 64'(Instr_Out), 64'(mon_e.instr));
                end else begin
                    check("round_trip", 64'(decode(mon_e.src, Instr_Out)), 64'(mon_e.imm));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (Done) done_pulses++;
    end

    // Present one item and hold it until accepted (bounded).
    task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base,
                        input logic last, input logic legal, input logic chk_instr,
                        input logic [31:0] exp_instr);
        int n;
        logic taken;
        n = 0;
        taken = 1'b0;
        ImmSrc   = src;
        Imm      = imm;
        Base     = base;
        Last     = last;
        In_Valid = 1'b1;
        if (legal) begin
            sb.push_back('{chk_instr, exp_instr, exp_addr, src, imm});
            exp_addr = last ? '0 : exp_addr + 10'd4;
        end else if (last) begin
            exp_addr = '0;
        end
        while (!taken && n < 50) begin
            @(negedge clk);
            taken = In_Ready;
            @(posedge clk);
            n++;
        end
        if (!taken) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no acceptance in 50 cycles, want acceptance");
        end
        #1;
        In_Valid = 1'b0;
        Last     = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [1:0]  rs;
        logic [31:0] ri;
        int          pulses_before;

        rst_n = 1'b0; In_Valid = 1'b0; ImmSrc = 2'b00; Imm = '0; Base = '0; Last = 1'b0;
        Out_Ready = 1'b0; Err_Clr = 1'b0; exp_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(Out_Valid), 64'd0);
        check("rst_instr", 64'(Instr_Out), 64'd0);
        check("rst_addr", 64'(Addr_Out), 64'd0);
        check("rst_err", 64'(Err), 64'd0);
        check("rst_err_count", 64'(Err_Count), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_in_ready", 64'(In_Ready), 64'd1);
        rst_n = 1'b1;
        Out_Ready = 1'b1;
        @(posedge clk);
        #1;

        // Directed I/S/B encodings, issued back to back.
        send(IMM_I, 32'hFFFF_FFFF, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 32'hFFF0_0013);
        send(IMM_S, 32'hFFFF_FFFC, 32'h0000_2023, 1'b0, 1'b1, 1'b1, 32'hFE00_2E23);
        send(IMM_B, 32'hFFFF_FFF8, 32'h0000_0063, 1'b0, 1'b1, 1'b1, 32'hFE00_0CE3);

        // Round trip with random legal immediates and random base words.
        for (int k = 0; k < 6; k++) begin
            rs = 2'(k % 3);
            ri = 32'($urandom_range(0, 4095)) - 32'd2048;
            if (rs == IMM_B) ri = ri << 1;
            send(rs, ri, $urandom, 1'b0, 1'b1, 1'b0, 32'd0);
        end
        drain();

        // Error items leave no word and do not move the address.
        send(IMM_I, 32'd2048, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'd0);
        check("err_i_flag", 64'(Err), 64'd1);
        check("err_i_count", 64'(Err_Count), 64'd1);
        check("err_i_no_word", 64'(Out_Valid), 64'd0);
        send(IMM_B, 32'd3, 32'h0000_0063, 1'b0, 1'b0, 1'b0, 32'd0);
        check("err_b_count", 64'(Err_Count), 64'd2);
        check("err_b_no_word", 64'(Out_Valid), 64'd0);
        send(IMM_I, 32'd5, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 32'h0050_0013);
        send(2'b11, 32'd0, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'd0);
        check("err_fmt_count", 64'(Err_Count), 64'd3);
        check("err_last_done", 64'(Done), 64'd1);
        @(posedge clk);
        #1;
        check("err_last_done_clear", 64'(Done), 64'd0);
        send(IMM_S, 32'd2047, 32'h0000_2023, 1'b0, 1'b1, 1'b1, 32'h7E00_2FA3);
        drain();

        Err_Clr = 1'b1;
        @(posedge clk);
        #1;
        Err_Clr = 1'b0;
        check("clr_err", 64'(Err), 64'd0);
        check("clr_count", 64'(Err_Count), 64'd0);
        send(IMM_S, 32'hFFFF_F7FF, 32'h0000_2023, 1'b0, 1'b0, 1'b0, 32'd0);
        send(IMM_B, 32'd4096, 32'h0000_0063, 1'b0, 1'b0, 1'b0, 32'd0);
        check("pre_clr_count", 64'(Err_Count), 64'd2);
        Err_Clr = 1'b1;
        send(IMM_I, 32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'd0);
        Err_Clr = 1'b0;
        check("clr_vs_err_flag", 64'(Err), 64'd1);
        check("clr_vs_err_count", 64'(Err_Count), 64'd1);

        // Program completion: Done one cycle after the Last word leaves.
        pulses_before = done_pulses;
        send(IMM_I, 32'd100, 32'h0000_0093, 1'b0, 1'b1, 1'b1, 32'h0640_0093);
        send(IMM_S, 32'd8, 32'h0000_2023, 1'b0, 1'b1, 1'b1, 32'h0000_2423);
        send(IMM_B, 32'd16, 32'h0000_0063, 1'b1, 1'b1, 1'b1, 32'h0000_0863);
        check("done_early", 64'(Done), 64'd0);
        @(posedge clk);
        #1;
        check("done_pulse", 64'(Done), 64'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(Done), 64'd0);
        send(IMM_I, 32'hFFFF_F800, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 32'h8000_0013);
        drain();
        check("done_pulse_count", 64'(done_pulses - pulses_before), 64'd1);

        // Reset while a word is held.
        Out_Ready = 1'b0;
        send(IMM_I, 32'd1, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 32'h0010_0013);
        check("held_before_reset", 64'(Out_Valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(Out_Valid), 64'd0);
        check("mid_rst_instr", 64'(Instr_Out), 64'd0);
        check("mid_rst_addr", 64'(Addr_Out), 64'd0);
        check("mid_rst_err", 64'(Err), 64'd0);
        check("mid_rst_err_count", 64'(Err_Count), 64'd0);
        check("mid_rst_done", 64'(Done), 64'd0);
        sb.delete();
        exp_addr = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Backpressure: second item waits, held word stays stable.
        send(IMM_I, 32'd7, 32'h0000_0013, 1'b0, 1'b1, 1'b1, 32'h0070_0013);
        ImmSrc = IMM_S; Imm = 32'hFFFF_FFFF; Base = 32'h0000_2023; In_Valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(In_Ready), 64'd0);
            check("stall_instr", 64'(Instr_Out), 64'h0070_0013);
            check("stall_addr", 64'(Addr_Out), 64'd0);
            @(posedge clk);
            #1;
        end
        Out_Ready = 1'b1;
        send(IMM_S, 32'hFFFF_FFFF, 32'h0000_2023, 1'b0, 1'b1, 1'b1, 32'hFE00_2FA3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
